// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, PC+STEP, next-PC select and fetch handshake.
// Optional misaligned-target trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_sequencer #(
  parameter int                   PC_WIDTH     = 32,
  parameter int                   STEP         = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
  parameter logic [PC_WIDTH-1:0]  TRAP_VECTOR  = PC_WIDTH'('h80),
  parameter int                   CNT_WIDTH    = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Stall,
  input  logic                 FetchReady,
  input  logic                 BranchTaken,
  input  logic [PC_WIDTH-1:0]  BranchTarget,
  input  logic                 JumpEn,
  input  logic [PC_WIDTH-1:0]  JumpTarget,
  input  logic                 FlushEn,
  input  logic [PC_WIDTH-1:0]  FlushTarget,
  input  logic                 Halt,
  output logic [PC_WIDTH-1:0]  PCResult,
  output logic [PC_WIDTH-1:0]  PCAddResult,
  output logic                 PCValid,
  output logic [CNT_WIDTH-1:0] FetchCount,
  output logic [1:0]           State
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic                 MisalignTrap,
  output logic [PC_WIDTH-1:0]  BadAddr
`endif
);

  localparam logic [1:0] BOOT = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] HALT = 2'b10;

  localparam logic [PC_WIDTH-1:0] STEP_V     = PC_WIDTH'(STEP);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = STEP_V - PC_WIDTH'(1);

  logic                redirect;
  logic                fetch;
  logic                misalign;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] next_pc;
  logic [1:0]          next_state;

  assign redirect    = FlushEn | JumpEn | BranchTaken;
  assign fetch       = PCValid & FetchReady;
  assign PCAddResult = PCResult + STEP_V;

  // Only the highest-priority redirect is selected, so only it is alignment-checked.
  always_comb begin
    target = BranchTarget;
    if (FlushEn)     target = FlushTarget;
    else if (JumpEn) target = JumpTarget;
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign misalign = redirect && ((target & ALIGN_MASK) != '0);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    next_state = State;
    case (State)
      BOOT:    next_state = RUN;
      RUN:     if (Halt && !redirect) next_state = HALT;
      HALT:    if (redirect) next_state = RUN;
      default: next_state = BOOT;
    endcase
  end

  // Redirects win over Stall/FetchReady; nothing loads while still in BOOT.
  always_comb begin
    next_pc = PCResult;
    if (State != BOOT) begin
      if (redirect)            next_pc = misalign ? TRAP_VECTOR : target;
      else if (fetch && !Stall) next_pc = PCResult + STEP_V;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      State      <= BOOT;
      PCResult   <= RESET_VECTOR;
      PCValid    <= 1'b0;
      FetchCount <= '0;
    end else begin
      State    <= next_state;
      PCResult <= next_pc;
      PCValid  <= (next_state == RUN);
      if (fetch && !(&FetchCount))
        FetchCount <= FetchCount + CNT_WIDTH'(1);
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      MisalignTrap <= 1'b0;
      BadAddr      <= '0;
    end else begin
      MisalignTrap <= misalign && (State != BOOT);
      if (misalign && (State != BOOT))
        BadAddr <= target;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized run
// against a cycle-level reference model of the sequencing rules.
module tb_pc_sequencer;
  localparam int PW = 32;
  localparam int CW = 4;
`ifdef PC_MISALIGN_TRAP_EN
  localparam int OW = 2*PW + CW + 3 + 1 + PW;
`else
  localparam int OW = 2*PW + CW + 3;
`endif

  logic          Clk;
  logic          Reset, Stall, FetchReady, BranchTaken, JumpEn, FlushEn, Halt;
  logic [PW-1:0] BranchTarget, JumpTarget, FlushTarget;
  logic [PW-1:0] PCResult, PCAddResult;
  logic          PCValid;
  logic [CW-1:0] FetchCount;
  logic [1:0]    State;
`ifdef PC_MISALIGN_TRAP_EN
  logic          MisalignTrap;
  logic [PW-1:0] BadAddr;
`endif

  int checks = 0;
  int passes = 0;

  // Reference model: phase 0 boot, 1 run, 2 halt
  int            m_phase;
  logic [PW-1:0] m_pc;
  int            m_cnt;
  logic          m_trap;
  logic [PW-1:0] m_bad;

  pc_sequencer #(.CNT_WIDTH(CW)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .FetchReady(FetchReady),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .JumpEn(JumpEn), .JumpTarget(JumpTarget),
    .FlushEn(FlushEn), .FlushTarget(FlushTarget), .Halt(Halt),
    .PCResult(PCResult), .PCAddResult(PCAddResult), .PCValid(PCValid),
    .FetchCount(FetchCount), .State(State)
`ifdef PC_MISALIGN_TRAP_EN
    , .MisalignTrap(MisalignTrap), .BadAddr(BadAddr)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

`ifdef PC_MISALIGN_TRAP_EN
  wire [OW-1:0] obs = {PCResult, PCAddResult, PCValid, FetchCount, State, MisalignTrap, BadAddr};
`else
  wire [OW-1:0] obs = {PCResult, PCAddResult, PCValid, FetchCount, State};
`endif

  function automatic logic [OW-1:0] expected();
    logic [PW-1:0] add;
    add = m_pc + 32'd4;
`ifdef PC_MISALIGN_TRAP_EN
    return {m_pc, add, (m_phase == 1), CW'(m_cnt), 2'(m_phase), m_trap, m_bad};
`else
    return {m_pc, add, (m_phase == 1), CW'(m_cnt), 2'(m_phase)};
`endif
  endfunction

  task automatic model_reset();
    m_phase = 0; m_pc = '0; m_cnt = 0; m_trap = 1'b0; m_bad = '0;
  endtask

  task automatic model_clock();
    logic          fetch, redir;
    logic [PW-1:0] tgt;
    m_trap = 1'b0;
    if (m_phase == 0) begin
      m_phase = 1;
      return;
    end
    fetch = (m_phase == 1) && FetchReady;
    redir = FlushEn || JumpEn || BranchTaken;
    if (fetch && m_cnt < (1 << CW) - 1) m_cnt++;
    tgt = FlushEn ? FlushTarget : JumpEn ? JumpTarget : BranchTarget;
    if (redir) begin
`ifdef PC_MISALIGN_TRAP_EN
      if (tgt % 4 != 0) begin
        m_pc = 32'h80; m_trap = 1'b1; m_bad = tgt;
      end else m_pc = tgt;
`else
      m_pc = tgt;
`endif
    end else if (fetch && !Stall) m_pc = m_pc + 32'd4;
    if (m_phase == 1 && Halt && !redir) m_phase = 2;
    else if (m_phase == 2 && redir)     m_phase = 1;
  endtask

  task automatic clear_in();
    Stall = 0; FetchReady = 0; BranchTaken = 0; JumpEn = 0; FlushEn = 0; Halt = 0;
    BranchTarget = '0; JumpTarget = '0; FlushTarget = '0;
  endtask

  task automatic tick();
    @(posedge Clk);
    if (Reset) model_clock();
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 0; clear_in(); model_reset();
    repeat (2) @(negedge Clk);
    checks++;
    if (obs !== expected()) $display("FAIL reset_state: got %h want %h", obs, expected());
    else passes++;
    checks++;
    if (PCAddResult !== 32'h4 || PCValid !== 1'b0 || State !== 2'b00)
      $display("FAIL reset_values: add=%h valid=%b state=%b want 4/0/00", PCAddResult, PCValid, State);
    else passes++;
    Reset = 1;
    tick();
    checks++;
    if (State !== 2'b01 || PCValid !== 1'b1 || PCResult !== 32'h0 || PCAddResult !== 32'h4)
      $display("FAIL boot_to_run: state=%b valid=%b pc=%h add=%h want 01/1/0/4", State, PCValid, PCResult, PCAddResult);
    else passes++;
  endtask

  task automatic test_sequential();
    FetchReady = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== expected()) $display("FAIL seq_step%0d: got %h want %h", i, obs, expected());
      else passes++;
    end
    checks++;
    if (PCResult !== 32'hC || FetchCount !== 4'd3)
      $display("FAIL seq_pc_count: pc=%h cnt=%0d want C/3", PCResult, FetchCount);
    else passes++;
    Stall = 1;
    repeat (2) tick();
    checks++;
    if (PCResult !== 32'hC || FetchCount !== 4'd5)
      $display("FAIL stall_hold: pc=%h cnt=%0d want C/5", PCResult, FetchCount);
    else passes++;
    clear_in();
  endtask

  task automatic test_priority();
    BranchTaken = 1; BranchTarget = 32'h100;
    JumpEn = 1;      JumpTarget   = 32'h200;
    FlushEn = 1;     FlushTarget  = 32'h300;
    tick();
    checks++;
    if (PCResult !== 32'h300) $display("FAIL prio_flush: pc=%h want 300", PCResult);
    else passes++;
    FlushEn = 0;
    tick();
    checks++;
    if (PCResult !== 32'h200) $display("FAIL prio_jump: pc=%h want 200", PCResult);
    else passes++;
    JumpEn = 0;
    tick();
    checks++;
    if (obs !== expected() || PCResult !== 32'h100)
      $display("FAIL prio_branch: got %h want %h", obs, expected());
    else passes++;
    clear_in();
  endtask

  task automatic test_wrap();
    JumpEn = 1; JumpTarget = 32'hFFFF_FFFC;
    tick();
    checks++;
    if (PCResult !== 32'hFFFF_FFFC || PCAddResult !== 32'h0)
      $display("FAIL wrap_load: pc=%h add=%h want FFFFFFFC/0", PCResult, PCAddResult);
    else passes++;
    JumpEn = 0; FetchReady = 1;
    tick();
    checks++;
    if (PCResult !== 32'h0) $display("FAIL wrap_adv: pc=%h want 0", PCResult);
    else passes++;
    clear_in();
  endtask

  task automatic test_halt();
    logic [PW-1:0] pc0;
    logic [CW-1:0] c0;
    pc0 = PCResult; c0 = FetchCount;
    Halt = 1;
    tick();
    checks++;
    if (PCValid !== 1'b0 || State !== 2'b10)
      $display("FAIL halt_enter: valid=%b state=%b want 0/10", PCValid, State);
    else passes++;
    FetchReady = 1;
    repeat (3) tick();
    checks++;
    if (PCResult !== pc0 || FetchCount !== c0 || State !== 2'b10)
      $display("FAIL halt_frozen: pc=%h cnt=%0d state=%b want %h/%0d/10", PCResult, FetchCount, State, pc0, c0);
    else passes++;
    BranchTaken = 1; BranchTarget = 32'h40;
    tick();
    checks++;
    if (State !== 2'b01 || PCResult !== 32'h40 || PCValid !== 1'b1)
      $display("FAIL halt_exit: state=%b pc=%h valid=%b want 01/40/1", State, PCResult, PCValid);
    else passes++;
    clear_in();
  endtask

  task automatic test_saturation();
    FetchReady = 1;
    repeat (20) tick();
    checks++;
    if (FetchCount !== 4'hF || obs !== expected())
      $display("FAIL count_sat: cnt=%0d want 15; got %h want %h", FetchCount, obs, expected());
    else passes++;
    clear_in();
  endtask

  task automatic test_misalign();
    JumpEn = 1; JumpTarget = 32'h102;
    tick();
`ifdef PC_MISALIGN_TRAP_EN
    checks++;
    if (PCResult !== 32'h80 || MisalignTrap !== 1'b1 || BadAddr !== 32'h102)
      $display("FAIL trap_fire: pc=%h trap=%b bad=%h want 80/1/102", PCResult, MisalignTrap, BadAddr);
    else passes++;
    JumpEn = 0;
    tick();
    checks++;
    if (MisalignTrap !== 1'b0 || BadAddr !== 32'h102)
      $display("FAIL trap_pulse: trap=%b bad=%h want 0/102", MisalignTrap, BadAddr);
    else passes++;
`else
    checks++;
    if (PCResult !== 32'h102) $display("FAIL verbatim_target: pc=%h want 102", PCResult);
    else passes++;
`endif
    clear_in();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      Reset       = ($urandom_range(0, 49) != 0);
      Stall       = ($urandom_range(0, 3) == 0);
      FetchReady  = ($urandom_range(0, 3) != 0);
      FlushEn     = ($urandom_range(0, 15) == 0);
      JumpEn      = ($urandom_range(0, 11) == 0);
      BranchTaken = ($urandom_range(0, 9) == 0);
      Halt        = ($urandom_range(0, 9) == 0);
      FlushTarget  = $urandom();
      JumpTarget   = $urandom();
      BranchTarget = $urandom();
      if ($urandom_range(0, 7) != 0) begin
        FlushTarget[1:0] = 2'b00; JumpTarget[1:0] = 2'b00; BranchTarget[1:0] = 2'b00;
      end
      if (!Reset) model_reset();
      tick();
      checks++;
      if (obs !== expected()) $display("FAIL random_cyc%0d: got %h want %h", i, obs, expected());
      else passes++;
    end
    Reset = 1; clear_in();
  endtask

  task automatic test_midrun_reset();
    FetchReady = 1;
    repeat (4) tick();
    @(posedge Clk);
    model_clock();
    #2 Reset = 0;
    #1;
    checks++;
    if (PCResult !== 32'h0 || PCAddResult !== 32'h4 || PCValid !== 1'b0 || FetchCount !== '0 || State !== 2'b00)
      $display("FAIL async_reset: pc=%h add=%h valid=%b cnt=%0d state=%b want 0/4/0/0/00",
               PCResult, PCAddResult, PCValid, FetchCount, State);
    else passes++;
    model_reset();
    @(negedge Clk);
    Reset = 1;
    tick();
    checks++;
    if (obs !== expected() || State !== 2'b01)
      $display("FAIL reset_recover: got %h want %h", obs, expected());
    else passes++;
    clear_in();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sequential();
    test_priority();
    test_wrap();
    test_halt();
    test_saturation();
    test_misalign();
    test_random();
    test_midrun_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
